stage_eval: RTL and testbench

- Downstream partner of the cascade ROM sequencer. Consumes its per-feature read strobes and stage-boundary indications.
- Accumulates the selected weak-classifier values returned by the feature datapath.
- At each stage boundary, compares the accumulated sum against the stage threshold. It then issues next_stage_o to advance the cascade, or break_o to reject the window or finish it as a face.
- Provides the wait_o back-pressure that stalls ROM addressing while weak results are outstanding.

---
 rtl/stage_eval.sv | 164 ++++++++++++++++
 tb/tb_stage_eval.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_eval.sv
// Cascade stage evaluator: sums weak-classifier results, compares to the stage threshold, one-cycle registered decision.
// Back-pressure: wait_o stalls ROM addressing while idle or while MAX_OUTST weak reads are outstanding.
module stage_eval #(
   parameter int VAL_WIDTH = 16,
   parameter int ACC_WIDTH = 24,
   parameter int MAX_OUTST = 4,
   parameter int STAGE_CNT = 22
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 win_start_i,
   input  logic                 rom_val_i,
   input  logic                 weak_val_i,
   input  logic [VAL_WIDTH-1:0] weak_value_i,
   input  logic                 stage_val_i,
   input  logic                 stage_last_i,
   input  logic [VAL_WIDTH-1:0] stage_thr_i,
   output logic                 next_stage_o,
   output logic                 break_o,
   output logic                 wait_o,
   output logic                 ready_o,
   output logic                 res_val_o,
   output logic                 res_face_o,
   output logic [4:0]           res_stages_o,
   output logic                 err_o
);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, RUN} state_t;
   typedef struct packed {
      logic       face;
      logic [4:0] stages;
   } res_t;

   state_t                      state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [OW-1:0]               outst_q, outst_d;
   logic [4:0]                  stages_q, stages_d;
   logic [1:0]                  holdoff_q, holdoff_d;
   logic                        err_q, err_d;
   logic                        next_q, next_d;
   logic                        brk_q, brk_d;
   logic                        res_val_q, res_val_d;
   res_t                        res_q, res_d;

   logic signed [ACC_WIDTH:0]   sum_w;
   logic signed [ACC_WIDTH-1:0] thr_ext;
   logic signed [ACC_WIDTH-1:0] acc_sat;
   logic                        weak_ok;
   logic                        decide;
   logic                        pass;
   logic                        overrun;

   // One extra accumulator bit exposes signed overflow so the sum clamps instead of wrapping.
   always_comb begin
      thr_ext = {{(ACC_WIDTH-VAL_WIDTH){stage_thr_i[VAL_WIDTH-1]}}, stage_thr_i};
      sum_w   = {acc_q[ACC_WIDTH-1], acc_q}
              + {{(ACC_WIDTH+1-VAL_WIDTH){weak_value_i[VAL_WIDTH-1]}}, weak_value_i};
      if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
         acc_sat = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sat = sum_w[ACC_WIDTH-1:0];
      end
      weak_ok = weak_val_i && (outst_q != '0);
      decide  = (state_q == RUN) && stage_val_i && (outst_q == '0) && !weak_val_i
              && (holdoff_q == 2'd0);
      pass    = (acc_q >= thr_ext);
      overrun = ({1'b0, stages_q} + 6'd1) > 6'(STAGE_CNT);
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      outst_d   = outst_q;
      stages_d  = stages_q;
      holdoff_d = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : holdoff_q;
      err_d     = err_q;
      next_d    = 1'b0;
      brk_d     = 1'b0;
      res_val_d = 1'b0;
      res_d     = res_q;
      case (state_q)
         IDLE: begin
            if (win_start_i) begin
               state_d   = RUN;
               acc_d     = '0;
               outst_d   = '0;
               stages_d  = '0;
               holdoff_d = 2'd0;
               err_d     = 1'b0;
            end
         end
         RUN: begin
            if (weak_val_i && (outst_q == '0)) err_d = 1'b1;
            if (weak_ok) acc_d = acc_sat;
            if (rom_val_i && !weak_ok) begin
               if (outst_q == OUTST_MAX) err_d = 1'b1;
               else outst_d = outst_q + 1'b1;
            end else if (!rom_val_i && weak_ok) begin
               outst_d = outst_q - 1'b1;
            end
            if (decide) begin
               if (pass && !stage_last_i && !overrun) begin
                  next_d    = 1'b1;
                  acc_d     = '0;
                  stages_d  = stages_q + 5'd1;
                  holdoff_d = 2'd2;
               end else begin
                  brk_d     = 1'b1;
                  res_val_d = 1'b1;
                  state_d   = IDLE;
                  if (pass && stage_last_i) begin
                     res_d.face   = 1'b1;
                     res_d.stages = stages_q + 5'd1;
                  end else begin
                     // A pass that would run past the last stage is a sequencer fault.
                     res_d.face   = 1'b0;
                     res_d.stages = stages_q;
                     if (pass) err_d = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         outst_q   <= '0;
         stages_q  <= '0;
         holdoff_q <= 2'd0;
         err_q     <= 1'b0;
         next_q    <= 1'b0;
         brk_q     <= 1'b0;
         res_val_q <= 1'b0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         outst_q   <= outst_d;
         stages_q  <= stages_d;
         holdoff_q <= holdoff_d;
         err_q     <= err_d;
         next_q    <= next_d;
         brk_q     <= brk_d;
         res_val_q <= res_val_d;
         res_q     <= res_d;
      end
   end

   assign next_stage_o = next_q;
   assign break_o      = brk_q;
   assign res_val_o    = res_val_q;
   assign res_face_o   = res_q.face;
   assign res_stages_o = res_q.stages;
   assign err_o        = err_q;
   assign ready_o      = (state_q == IDLE);
   assign wait_o       = (state_q == IDLE) || (outst_q >= OUTST_MAX);
endmodule

// File: tb/tb_stage_eval.sv
// Bench for stage_eval: vector table of single-stage windows plus hand sequences; results checked via a queue.
module tb_stage_eval;
   localparam int VW = 16;
   localparam int AW = 24;
   localparam int MO = 4;
   localparam int SC = 22;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          win_start_i = 1'b0;
   logic          rom_val_i = 1'b0;
   logic          weak_val_i = 1'b0;
   logic [VW-1:0] weak_value_i = '0;
   logic          stage_val_i = 1'b0;
   logic          stage_last_i = 1'b0;
   logic [VW-1:0] stage_thr_i = '0;
   logic          next_stage_o, break_o, wait_o, ready_o;
   logic          res_val_o, res_face_o, err_o;
   logic [4:0]    res_stages_o;

   always #5 clk_i = ~clk_i;

   stage_eval #(.VAL_WIDTH(VW), .ACC_WIDTH(AW), .MAX_OUTST(MO), .STAGE_CNT(SC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .win_start_i(win_start_i), .rom_val_i(rom_val_i),
      .weak_val_i(weak_val_i), .weak_value_i(weak_value_i), .stage_val_i(stage_val_i),
      .stage_last_i(stage_last_i), .stage_thr_i(stage_thr_i), .next_stage_o(next_stage_o),
      .break_o(break_o), .wait_o(wait_o), .ready_o(ready_o), .res_val_o(res_val_o),
      .res_face_o(res_face_o), .res_stages_o(res_stages_o), .err_o(err_o));

   typedef struct packed {
      logic       face;
      logic [4:0] stages;
   } res_t;

   typedef struct {
      int                   nw;
      logic signed [VW-1:0] w0, w1, w2;
      logic signed [VW-1:0] thr;
      logic                 last;
      int                   pre;
      logic                 exp_next;
      logic                 exp_face;
      int                   exp_stages;
   } vec_t;

   res_t exp_q[$];
   res_t mon_e;
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      if (res_val_o) begin
         if (exp_q.size() == 0) begin
            chk("res_unexpected", int'(res_val_o), 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res_face", int'(res_face_o), int'(mon_e.face));
            chk("res_stages", int'(res_stages_o), int'(mon_e.stages));
         end
      end
      if (next_stage_o || break_o) chk("pulse_excl", int'(next_stage_o & break_o), 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic start_win();
      int n;
      n = 0;
      while (!ready_o && n < 50) begin
         tick();
         n++;
      end
      chk("ready_wait", int'(ready_o), 1);
      win_start_i = 1'b1;
      tick();
      win_start_i = 1'b0;
      chk("start_ready", int'(ready_o), 0);
      chk("start_err", int'(err_o), 0);
   endtask

   task automatic run_weaks(input int nw, input logic signed [VW-1:0] w0,
                            input logic signed [VW-1:0] w1, input logic signed [VW-1:0] w2);
      rom_val_i = 1'b1;
      repeat (nw) tick();
      rom_val_i = 1'b0;
      for (int i = 0; i < nw; i++) begin
         weak_val_i   = 1'b1;
         weak_value_i = (i == 0) ? w0 : (i == 1) ? w1 : w2;
         tick();
      end
      weak_val_i = 1'b0;
      tick();
   endtask

   task automatic do_stage(input logic signed [VW-1:0] thr, input logic last,
                           input logic exp_next, input logic exp_face, input int exp_st,
                           input string nm);
      res_t r;
      tick();
      tick();
      stage_val_i  = 1'b1;
      stage_thr_i  = thr;
      stage_last_i = last;
      if (!exp_next) begin
         r.face   = exp_face;
         r.stages = 5'(exp_st);
         exp_q.push_back(r);
      end
      tick();
      stage_val_i  = 1'b0;
      stage_last_i = 1'b0;
      chk({nm, "_next"}, int'(next_stage_o), int'(exp_next));
      chk({nm, "_break"}, int'(break_o), int'(!exp_next));
      tick();
      chk({nm, "_pulse_clr"}, int'(next_stage_o | break_o), 0);
      if (!exp_next) begin
         chk({nm, "_ready"}, int'(ready_o), 1);
         chk({nm, "_res_hold"}, int'(res_stages_o), exp_st);
         chk({nm, "_resval_clr"}, int'(res_val_o), 0);
      end
   endtask

   task automatic sat_run(input logic signed [VW-1:0] val, input logic signed [VW-1:0] thr,
                          input logic face, input string nm);
      start_win();
      rom_val_i = 1'b1;
      tick();
      weak_val_i   = 1'b1;
      weak_value_i = val;
      repeat (299) tick();
      rom_val_i = 1'b0;
      tick();
      weak_val_i = 1'b0;
      do_stage(thr, 1'b1, 1'b0, face, face ? 1 : 0, nm);
      chk({nm, "_err"}, int'(err_o), 0);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{3, 16'sd100, 16'sd50, -16'sd20, 16'sd130, 1'b0, 0, 1'b1, 1'b0, 1};
      vecs[1] = '{3, 16'sd100, 16'sd50, -16'sd20, 16'sd131, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[2] = '{2, 16'sd10, -16'sd15, 16'sd0, -16'sd5, 1'b1, 2, 1'b0, 1'b1, 3};
      vecs[3] = '{1, -16'sd100, 16'sd0, 16'sd0, -16'sd101, 1'b1, 0, 1'b0, 1'b1, 1};
      vecs[4] = '{1, -16'sd100, 16'sd0, 16'sd0, -16'sd99, 1'b1, 0, 1'b0, 1'b0, 0};
      vecs[5] = '{3, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 1'b0, 1, 1'b1, 1'b0, 2};
      vecs[6] = '{0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b1, 0, 1'b0, 1'b1, 1};

      tick();
      tick();
      chk("rst_ready", int'(ready_o), 1);
      chk("rst_wait", int'(wait_o), 1);
      chk("rst_next", int'(next_stage_o), 0);
      chk("rst_break", int'(break_o), 0);
      chk("rst_resval", int'(res_val_o), 0);
      chk("rst_face", int'(res_face_o), 0);
      chk("rst_stages", int'(res_stages_o), 0);
      chk("rst_err", int'(err_o), 0);
      rst_i = 1'b0;
      tick();

      for (int k = 0; k < 7; k++) begin
         start_win();
         for (int p = 0; p < vecs[k].pre; p++) begin
            run_weaks(1, 16'sd10, 16'sd0, 16'sd0);
            do_stage(16'sd0, 1'b0, 1'b1, 1'b0, 0, $sformatf("v%0d_pre%0d", k, p));
         end
         run_weaks(vecs[k].nw, vecs[k].w0, vecs[k].w1, vecs[k].w2);
         do_stage(vecs[k].thr, vecs[k].last, vecs[k].exp_next, vecs[k].exp_face,
                  vecs[k].exp_stages, $sformatf("v%0d", k));
         // A passed non-last stage must leave acc at zero: threshold 1 then fails.
         if (vecs[k].exp_next)
            do_stage(16'sd1, 1'b0, 1'b0, 1'b0, vecs[k].exp_stages, $sformatf("v%0d_close", k));
      end

      start_win();
      run_weaks(1, 16'sd5, 16'sd0, 16'sd0);
      tick();
      tick();
      stage_val_i = 1'b1;
      stage_thr_i = 16'sd0;
      tick();
      chk("hold_next", int'(next_stage_o), 1);
      stage_thr_i  = -16'sd1000;
      stage_last_i = 1'b1;
      tick();
      chk("hold_ign1", int'(break_o | next_stage_o), 0);
      tick();
      chk("hold_ign2", int'(break_o | next_stage_o), 0);
      stage_val_i  = 1'b0;
      stage_last_i = 1'b0;
      do_stage(-16'sd1000, 1'b1, 1'b0, 1'b1, 2, "hold_fin");

      start_win();
      rom_val_i = 1'b1;
      repeat (3) tick();
      chk("bp_3", int'(wait_o), 0);
      tick();
      chk("bp_4", int'(wait_o), 1);
      rom_val_i    = 1'b0;
      weak_val_i   = 1'b1;
      weak_value_i = '0;
      tick();
      chk("bp_ret", int'(wait_o), 0);
      rom_val_i = 1'b1;
      tick();
      chk("bp_both", int'(wait_o), 0);
      weak_val_i = 1'b0;
      tick();
      chk("bp_both_unch", int'(wait_o), 1);
      chk("bp_err", int'(err_o), 0);
      rom_val_i  = 1'b0;
      weak_val_i = 1'b1;
      repeat (4) tick();
      weak_val_i = 1'b0;
      do_stage(16'sd0, 1'b1, 1'b0, 1'b1, 1, "bp_fin");
      chk("bp_fin_err", int'(err_o), 0);

      sat_run(16'sd32767, 16'sd32767, 1'b1, "sat_pos");
      sat_run(-16'sd32768, 16'sd32767, 1'b0, "sat_neg");

      start_win();
      weak_val_i   = 1'b1;
      weak_value_i = 16'sd500;
      tick();
      weak_val_i = 1'b0;
      chk("err_set", int'(err_o), 1);
      run_weaks(1, 16'sd3, 16'sd0, 16'sd0);
      do_stage(16'sd4, 1'b1, 1'b0, 1'b0, 0, "err_acc");
      chk("err_sticky", int'(err_o), 1);
      start_win();
      rom_val_i = 1'b1;
      repeat (5) tick();
      rom_val_i = 1'b0;
      chk("err_ovf", int'(err_o), 1);
      chk("err_ovf_wait", int'(wait_o), 1);
      rst_i = 1'b1;
      tick();
      chk("mid_rst_ready", int'(ready_o), 1);
      chk("mid_rst_wait", int'(wait_o), 1);
      chk("mid_rst_resval", int'(res_val_o), 0);
      chk("mid_rst_break", int'(break_o), 0);
      rst_i = 1'b0;
      tick();
      start_win();
      run_weaks(1, 16'sd7, 16'sd0, 16'sd0);
      do_stage(16'sd7, 1'b1, 1'b0, 1'b1, 1, "post_rst");
      chk("post_rst_err", int'(err_o), 0);

      repeat (3) tick();
      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
